// File: rtl/counter_pkg.sv
// Shared types and next-value logic for the up/down modulo counter family.
// The step function works on a fixed 32-bit datapath so future counters can reuse it.
package counter_pkg;

    localparam int unsigned CNT_MAX_W = 32;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    typedef struct packed {
        logic [CNT_MAX_W-1:0] value;
        logic                 evt;   // boundary event: stepping outward from a range end
    } cnt_next_t;

    // Compare-before-step, so a modulus below 2**WIDTH-1 never yields an out-of-range value.
    function automatic cnt_next_t next_count(input logic [CNT_MAX_W-1:0] count,
                                             input logic                 up,
                                             input cnt_mode_e            mode,
                                             input logic [CNT_MAX_W-1:0] max);
        cnt_next_t res;
        logic      at_end;
        at_end = up ? (count >= max) : (count == '0);
        res.evt = at_end;
        if (at_end) begin
            if (mode == CNT_SAT) begin
                res.value = up ? max : '0;
            end else begin
                res.value = up ? '0 : max;
            end
        end else begin
            res.value = up ? (count + 32'd1) : (count - 32'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with clear, load, wrap/saturate mode and status flags.
// Priority each cycle: clr > load > en > hold. WIDTH must lie in 2..32.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             ovf_sticky
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    cnt_mode_e        mode;
    cnt_next_t        nxt;
    logic             boundary;

    assign mode = cnt_mode_e'(sat_mode);

    always_comb begin
        nxt      = next_count(CNT_MAX_W'(count_q), up, mode, CNT_MAX_W'(MAX_VAL));
        boundary = en && !clr && !load && nxt.evt;

        count_d = count_q;
        if (clr) begin
            count_d = RESET_VAL;
        end else if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            count_d = nxt.value[WIDTH-1:0];
        end

        wrap_d = boundary && (mode == CNT_WRAP);
        // A new overflow wins over a simultaneous clear request.
        ovf_d  = boundary ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

        tc = up ? (count_q == MAX_VAL) : (count_q == '0);
    end

    if (WIDTH < CNT_MAX_W) begin : g_unused_hi
        logic unused_nxt_hi;
        assign unused_nxt_hi = ^nxt.value[CNT_MAX_W-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed self-checking bench for counter_updown_mod (WIDTH=4, MAX_VAL=9, RESET_VAL=0).
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, load, up, sat_mode, ovf_clr;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc, wrap_pulse, ovf_sticky;

    int errors = 0;
    int checks = 0;

    counter_updown_mod #(
        .WIDTH    (4),
        .MAX_VAL  (4'd9),
        .RESET_VAL(4'd0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .up        (up),
        .sat_mode  (sat_mode),
        .ovf_clr   (ovf_clr),
        .count     (count),
        .tc        (tc),
        .wrap_pulse(wrap_pulse),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; samples are taken 1 time unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1;
        load_val = v;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        {en, clr, load, up, sat_mode, ovf_clr} = '0;
        load_val = '0;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap_pulse); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_sticky); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp;
        up = 1'b1; sat_mode = 1'b0; en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp = 4'(i % 10);
            checks++; if (count !== exp) begin errors++; $display("FAIL wrap_up_count[%0d] got=%0d exp=%0d", i, count, exp); end
            checks++; if (wrap_pulse !== (i == 10)) begin errors++; $display("FAIL wrap_up_pulse[%0d] got=%b exp=%b", i, wrap_pulse, i == 10); end
            checks++; if (ovf_sticky !== (i >= 10)) begin errors++; $display("FAIL wrap_up_ovf[%0d] got=%b exp=%b", i, ovf_sticky, i >= 10); end
        end
        en = 1'b0;
    endtask

    task automatic test_sat_down();
        logic [3:0] exp_c [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        logic       exp_o [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        ovf_clr = 1'b1;
        do_load(4'd2);
        ovf_clr = 1'b0;
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sat_pre_ovf got=%b exp=0", ovf_sticky); end
        up = 1'b0; sat_mode = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (count !== exp_c[i]) begin errors++; $display("FAIL sat_down_count[%0d] got=%0d exp=%0d", i, count, exp_c[i]); end
            checks++; if (tc !== (exp_c[i] == 4'd0)) begin errors++; $display("FAIL sat_down_tc[%0d] got=%b exp=%b", i, tc, exp_c[i] == 4'd0); end
            checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL sat_down_wrap[%0d] got=%b exp=0", i, wrap_pulse); end
            checks++; if (ovf_sticky !== exp_o[i]) begin errors++; $display("FAIL sat_down_ovf[%0d] got=%b exp=%b", i, ovf_sticky, exp_o[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_load_clamp();
        up = 1'b1;
        do_load(4'd15);
        checks++; if (count !== 4'd9) begin errors++; $display("FAIL load_clamp_count got=%0d exp=9", count); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL load_clamp_tc got=%b exp=1", tc); end
        checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL load_clamp_wrap got=%b exp=0", wrap_pulse); end
        do_load(4'd6);
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL load_plain got=%0d exp=6", count); end
        clr = 1'b1;
        do_load(4'd5);
        clr = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL clr_over_load got=%0d exp=0", count); end
    endtask

    task automatic test_ovf_clr_priority();
        up = 1'b1; sat_mode = 1'b0; en = 1'b0;
        do_load(4'd9);
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_pre got=%b exp=1", ovf_sticky); end
        en = 1'b1; ovf_clr = 1'b1;
        step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ovf_prio_count got=%0d exp=0", count); end
        checks++; if (wrap_pulse !== 1'b1) begin errors++; $display("FAIL ovf_prio_wrap got=%b exp=1", wrap_pulse); end
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_prio_set got=%b exp=1", ovf_sticky); end
        en = 1'b0;
        step();
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", ovf_sticky); end
        checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL ovf_clr_wrap got=%b exp=0", wrap_pulse); end
        ovf_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        up = 1'b1; sat_mode = 1'b0;
        do_load(4'd9);
        en = 1'b1;
        step();
        en = 1'b0;
        do_load(4'd4);
        en = 1'b1;
        step();
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL arst_pre_count got=%0d exp=5", count); end
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL arst_pre_ovf got=%b exp=1", ovf_sticky); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL arst_count got=%0d exp=0", count); end
        checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL arst_wrap got=%b exp=0", wrap_pulse); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL arst_ovf got=%b exp=0", ovf_sticky); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL arst_resume1 got=%0d exp=1", count); end
        step();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL arst_resume2 got=%0d exp=2", count); end
        en = 1'b0;
    endtask

    task automatic test_hold();
        clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up = i[0];
            sat_mode = i[1];
            #1;
            checks++; if (tc !== !up) begin errors++; $display("FAIL hold_tc[%0d] got=%b exp=%b", i, tc, !up); end
            step();
            checks++; if (count !== 4'd0) begin errors++; $display("FAIL hold_count[%0d] got=%0d exp=0", i, count); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_ovf_clr_priority();
        test_async_reset();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
